// File: rtl/max_pooling_if.sv
// max_pooling_if: window/result bundle for the 2x2 max-pooling cell.
// outIdx exists only when MAXPOOL_ARGMAX_EN is defined.
interface max_pooling_if #(parameter int DATA_W = 8);
  logic              enable;
  logic [DATA_W-1:0] in1, in2, in3, in4;
  logic [DATA_W-1:0] outMax;
  logic              outDone;
`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0]        outIdx;
  modport master(output enable, in1, in2, in3, in4, input outMax, outDone, outIdx);
  modport slave(input enable, in1, in2, in3, in4, output outMax, outDone, outIdx);
`else
  modport master(output enable, in1, in2, in3, in4, input outMax, outDone);
  modport slave(input enable, in1, in2, in3, in4, output outMax, outDone);
`endif
endinterface

// File: rtl/max_pooling.sv
// max_pooling: registered max of a 2x2 window, one window per cycle.
// Define MAXPOOL_ARGMAX_EN to also register the winning input index on outIdx.
module max_pooling #(
  parameter int DATA_W      = 8,
  parameter bit SIGNED_DATA = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  max_pooling_if.slave bus
);
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return SIGNED_DATA ? ($signed(a) > $signed(b)) : (a > b);
  endfunction
  logic [DATA_W-1:0] m01, m23, res;
  logic              s01, s23, s;
  // Strict compares: the right operand wins only when larger, so ties go to the lower index.
  always_comb begin
    s01 = gt(bus.in2, bus.in1);
    s23 = gt(bus.in4, bus.in3);
    m01 = s01 ? bus.in2 : bus.in1;
    m23 = s23 ? bus.in4 : bus.in3;
    s   = gt(m23, m01);
    res = s ? m23 : m01;
  end
`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0] idx;
  assign idx = s ? {1'b1, s23} : {1'b0, s01};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.outIdx <= '0;
    else if (bus.enable) bus.outIdx <= idx;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.outMax  <= '0;
      bus.outDone <= 1'b0;
    end else begin
      bus.outDone <= bus.enable;
      if (bus.enable) bus.outMax <= res;
    end
  end
endmodule

// File: tb/tb_max_pooling.sv
// tb_max_pooling: table-driven check of max_pooling, unsigned and signed instances.
module tb_max_pooling;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  max_pooling_if #(.DATA_W(8)) ub();
  max_pooling_if #(.DATA_W(8)) sb();
  assign sb.enable = ub.enable;
  assign sb.in1 = ub.in1;
  assign sb.in2 = ub.in2;
  assign sb.in3 = ub.in3;
  assign sb.in4 = ub.in4;
  max_pooling #(.DATA_W(8), .SIGNED_DATA(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(ub.slave));
  max_pooling #(.DATA_W(8), .SIGNED_DATA(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sb.slave));
  typedef struct {
    logic [7:0] a, b, c, d;
    logic [7:0] u_max;
    logic [1:0] u_idx;
    logic       chk_s;
    logic [7:0] s_max;
    logic [1:0] s_idx;
  } vec_t;
  vec_t vt[26];
  int checks = 0;
  int failures = 0;
  logic [7:0] l1[16];
  int sum;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic en, input logic [7:0] a, b, c, d);
    ub.enable = en;
    ub.in1 = a;
    ub.in2 = b;
    ub.in3 = c;
    ub.in4 = d;
  endtask
  initial begin
    vt[0]  = '{80, 30, 0, 255, 255, 3, 0, 0, 0};
    vt[1]  = '{145, 55, 58, 30, 145, 0, 0, 0, 0};
    vt[2]  = '{54, 67, 62, 29, 67, 1, 0, 0, 0};
    vt[3]  = '{39, 54, 145, 72, 145, 2, 0, 0, 0};
    vt[4]  = '{110, 18, 72, 39, 110, 0, 0, 0, 0};
    vt[5]  = '{31, 18, 0, 39, 39, 3, 0, 0, 0};
    vt[6]  = '{39, 40, 145, 54, 145, 2, 0, 0, 0};
    vt[7]  = '{50, 77, 24, 103, 103, 3, 0, 0, 0};
    vt[8]  = '{181, 58, 18, 84, 181, 0, 0, 0, 0};
    vt[9]  = '{70, 255, 39, 145, 255, 1, 0, 0, 0};
    vt[10] = '{50, 18, 210, 37, 210, 2, 0, 0, 0};
    vt[11] = '{94, 113, 115, 145, 145, 3, 0, 0, 0};
    vt[12] = '{67, 39, 18, 18, 67, 0, 0, 0, 0};
    vt[13] = '{72, 126, 113, 103, 126, 1, 0, 0, 0};
    vt[14] = '{0, 67, 145, 54, 145, 2, 0, 0, 0};
    vt[15] = '{47, 18, 0, 103, 103, 3, 0, 0, 0};
    vt[16] = '{7, 9, 9, 3, 9, 1, 0, 0, 0};
    vt[17] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    vt[18] = '{1, 2, 3, 200, 200, 3, 0, 0, 0};
    vt[19] = '{9, 3, 9, 9, 9, 0, 0, 0, 0};
    vt[20] = '{5, 5, 5, 5, 5, 0, 1, 5, 0};
    vt[21] = '{8'hFF, 8'h01, 8'h80, 8'h00, 8'hFF, 0, 1, 8'h01, 1};
    vt[22] = '{8'h80, 8'h81, 8'hFE, 8'h90, 8'hFE, 2, 1, 8'hFE, 2};
    vt[23] = '{8'h7F, 8'h80, 8'h7F, 8'h00, 8'h80, 1, 1, 8'h7F, 0};
    vt[24] = '{8'h80, 8'h00, 8'hC0, 8'h10, 8'hC0, 2, 1, 8'h10, 3};
    vt[25] = '{3, 8, 8, 1, 8, 1, 0, 0, 0};
    drive(1'b0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_max", ub.outMax, 0);
    chk("reset_done", ub.outDone, 0);
`ifdef MAXPOOL_ARGMAX_EN
    chk("reset_idx", ub.outIdx, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 80, 30, 0, 255);
    @(negedge clk);
    chk("first_max", ub.outMax, 255);
    chk("first_done", ub.outDone, 1);
    drive(1'b1, 145, 55, 58, 30);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_max", ub.outMax, 0);
    chk("async_rst_done", ub.outDone, 0);
    @(negedge clk);
    chk("in_reset_max", ub.outMax, 0);
    rst_n = 1'b1;
    drive(1'b0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_done", ub.outDone, 0);
    for (int i = 0; i < 26; i++) begin
      drive(1'b1, vt[i].a, vt[i].b, vt[i].c, vt[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d_max", i), ub.outMax, vt[i].u_max);
      chk($sformatf("vec%0d_done", i), ub.outDone, 1);
`ifdef MAXPOOL_ARGMAX_EN
      chk($sformatf("vec%0d_idx", i), ub.outIdx, vt[i].u_idx);
`endif
      if (vt[i].chk_s) begin
        chk($sformatf("vec%0d_smax", i), sb.outMax, vt[i].s_max);
`ifdef MAXPOOL_ARGMAX_EN
        chk($sformatf("vec%0d_sidx", i), sb.outIdx, vt[i].s_idx);
`endif
      end
      if (i < 16) l1[i] = ub.outMax;
    end
    drive(1'b0, 250, 250, 250, 250);
    @(negedge clk);
    chk("hold_max", ub.outMax, 8);
    chk("hold_done", ub.outDone, 0);
`ifdef MAXPOOL_ARGMAX_EN
    chk("hold_idx", ub.outIdx, 1);
`endif
    @(negedge clk);
    chk("hold2_max", ub.outMax, 8);
    sum = 0;
    for (int w = 0; w < 4; w++) begin
      int base;
      logic [7:0] exp2;
      base = (w / 2) * 8 + (w % 2) * 2;
      exp2 = (w == 0) ? 8'd255 : (w == 1) ? 8'd145 : (w == 2) ? 8'd255 : 8'd210;
      drive(1'b1, l1[base], l1[base + 1], l1[base + 4], l1[base + 5]);
      @(negedge clk);
      chk($sformatf("l2_win%0d_max", w), ub.outMax, exp2);
      chk($sformatf("l2_win%0d_done", w), ub.outDone, 1);
      sum += int'(ub.outMax);
    end
    chk("l2_sum", sum, 865);
    drive(1'b0, 0, 0, 0, 0);
    @(negedge clk);
    chk("end_hold_max", ub.outMax, 210);
    chk("end_hold_done", ub.outDone, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
